// File: rtl/score_display.sv
// Score display back-end: sequential binary-to-BCD conversion of the game score and a
// time-multiplexed, leading-zero-blanked, common-anode 4-digit seven-segment driver.
module score_display #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [9:0]  score,
    input  logic        blank_zeros,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic [15:0] bcd,
    output logic        busy
);

    localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

    state_e             state_q, state_d;
    logic [9:0]         s1_q, s2_q;
    logic [9:0]         last_q, last_d;
    logic [25:0]        sr_q, sr_d, sr_adj;
    logic [3:0]         iter_q, iter_d;
    logic [15:0]        bcd_q, bcd_d;
    logic               busy_q, busy_d;
    logic [ScanW-1:0]   scan_q, scan_d;
    logic [1:0]         idx_q, idx_d;
    logic [6:0]         seg_q, seg_d;
    logic [3:0]         an_q, an_d;
    logic [3:0]         nib;
    logic               blank;

    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Conversion FSM and double-dabble datapath
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        iter_d  = iter_q;
        last_d  = last_q;
        bcd_d   = bcd_q;
        sr_adj  = sr_q;
        for (int i = 0; i < 4; i++) begin
            if (sr_q[10+4*i +: 4] >= 4'd5) begin
                sr_adj[10+4*i +: 4] = sr_q[10+4*i +: 4] + 4'd3;
            end
        end
        case (state_q)
            StIdle: begin
                if ((s1_q == s2_q) && (s2_q != last_q)) state_d = StLoad;
            end
            StLoad: begin
                sr_d    = {16'b0, s2_q};
                last_d  = s2_q;
                iter_d  = 4'd0;
                state_d = StShift;
            end
            StShift: begin
                sr_d   = {sr_adj[24:0], 1'b0};
                iter_d = iter_q + 4'd1;
                if (iter_q == 4'd9) state_d = StDone;
            end
            StDone: begin
                bcd_d   = sr_q[25:10];
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Rises as LOAD is entered, falls one cycle after DONE, so back-to-back
        // conversions always show a one-cycle gap.
        busy_d = (state_q != StIdle) || ((state_d == StLoad) && !busy_q);
    end

    // Digit scan and output drive
    always_comb begin
        scan_d = (scan_q == ScanW'(SCAN_DIV - 1)) ? '0 : scan_q + 1'b1;
        idx_d  = (scan_q == ScanW'(SCAN_DIV - 1)) ? idx_q + 2'd1 : idx_q;
        nib    = 4'd0;
        blank  = 1'b0;
        case (idx_q)
            2'd0: nib = bcd_q[3:0];
            2'd1: begin
                nib   = bcd_q[7:4];
                blank = blank_zeros && (bcd_q[15:4] == 12'd0);
            end
            2'd2: begin
                nib   = bcd_q[11:8];
                blank = blank_zeros && (bcd_q[15:8] == 8'd0);
            end
            default: begin
                nib   = bcd_q[15:12];
                blank = blank_zeros && (bcd_q[15:12] == 4'd0);
            end
        endcase
        seg_d = blank ? 7'h7F : seg_enc(nib);
        an_d  = blank ? 4'hF : ~(4'b1 << idx_q);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            s1_q    <= '0;
            s2_q    <= '0;
            last_q  <= '0;
            sr_q    <= '0;
            iter_q  <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            scan_q  <= '0;
            idx_q   <= '0;
            seg_q   <= 7'h7F;
            an_q    <= 4'hF;
        end else begin
            state_q <= state_d;
            s1_q    <= score;
            s2_q    <= s1_q;
            last_q  <= last_d;
            sr_q    <= sr_d;
            iter_q  <= iter_d;
            bcd_q   <= bcd_d;
            busy_q  <= busy_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign bcd  = bcd_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_score_display.sv
// Directed self-checking bench for score_display with a short scan period.
module tb_score_display;

    logic        clock;
    logic        reset;
    logic [9:0]  score;
    logic        blank_zeros;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] bcd;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    score_display #(.SCAN_DIV(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .score       (score),
        .blank_zeros (blank_zeros),
        .seg         (seg),
        .an          (an),
        .bcd         (bcd),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic settle(input logic [9:0] v);
        @(negedge clock);
        score = v;
        repeat (20) @(negedge clock);
    endtask

    // One full refresh: collect the segment pattern shown for each enabled digit.
    task automatic frame(output logic [27:0] segs, output logic [3:0] lit);
        segs = '1;
        lit  = 4'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            case (an)
                4'b1110: begin lit[0] = 1'b1; segs[6:0]   = seg; end
                4'b1101: begin lit[1] = 1'b1; segs[13:7]  = seg; end
                4'b1011: begin lit[2] = 1'b1; segs[20:14] = seg; end
                4'b0111: begin lit[3] = 1'b1; segs[27:21] = seg; end
                default: ;
            endcase
        end
    endtask

    initial begin
        logic [27:0] segs;
        logic [3:0]  lit;
        int          nbusy;
        int          rises;
        logic        prev;

        reset       = 1'b0;
        score       = 10'd0;
        blank_zeros = 1'b1;

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_bcd", 32'(bcd), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        // Units slot lasts 4 cycles, then blanked tens slot
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("units_an", 32'(an), 32'hE);
            chk("units_seg", 32'(seg), 32'h40);
        end
        @(negedge clock);
        chk("tens_blank_an", 32'(an), 32'hF);
        chk("tens_blank_seg", 32'(seg), 32'h7F);

        // 0 -> 123: latency and busy width
        @(negedge clock);
        score = 10'd123;
        nbusy = 0;
        for (int k = 0; k <= 16; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (busy) nbusy++;
            if (k == 1)  chk("busy_e1", 32'(busy), 32'd0);
            if (k == 2)  chk("busy_e2", 32'(busy), 32'd1);
            if (k == 13) chk("bcd_e13", 32'(bcd), 32'h0000);
            if (k == 14) chk("bcd_e14", 32'(bcd), 32'h0123);
            if (k == 14) chk("busy_e14", 32'(busy), 32'd1);
            if (k == 15) chk("busy_e15", 32'(busy), 32'd0);
        end
        chk("busy_cycles", 32'(nbusy), 32'd13);
        frame(segs, lit);
        chk("f123_lit", 32'(lit), 32'h7);
        chk("f123_segs", 32'(segs), 32'({7'h7F, 7'h79, 7'h24, 7'h30}));

        // Boundary values
        settle(10'd1023);
        chk("bcd_1023", 32'(bcd), 32'h1023);
        settle(10'd999);
        chk("bcd_999", 32'(bcd), 32'h0999);
        settle(10'd1000);
        chk("bcd_1000", 32'(bcd), 32'h1000);
        frame(segs, lit);
        chk("f1000_lit", 32'(lit), 32'hF);
        chk("f1000_segs", 32'(segs), 32'({7'h79, 7'h40, 7'h40, 7'h40}));

        // 45, changed to 47 at E6
        @(negedge clock);
        score = 10'd45;
        rises = 0;
        prev  = busy;
        for (int k = 0; k <= 35; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (busy && !prev) rises++;
            prev = busy;
            if (k == 5)  score = 10'd47;
            if (k == 14) chk("bcd_45", 32'(bcd), 32'h0045);
            if (k == 35) chk("bcd_47", 32'(bcd), 32'h0047);
        end
        chk("busy_rises", 32'(rises), 32'd2);

        // One-cycle glitch is ignored
        settle(10'd7);
        chk("bcd_7", 32'(bcd), 32'h0007);
        @(negedge clock);
        score = 10'd512;
        @(negedge clock);
        score = 10'd7;
        nbusy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (busy) nbusy++;
        end
        chk("glitch_busy", 32'(nbusy), 32'd0);
        chk("glitch_bcd", 32'(bcd), 32'h0007);

        // Blanking disabled
        blank_zeros = 1'b0;
        settle(10'd5);
        chk("bcd_5", 32'(bcd), 32'h0005);
        frame(segs, lit);
        chk("f5_lit", 32'(lit), 32'hF);
        chk("f5_segs", 32'(segs), 32'({7'h40, 7'h40, 7'h40, 7'h12}));

        // Asynchronous reset in the middle of SHIFT
        @(negedge clock);
        score = 10'd900;
        for (int k = 0; k <= 6; k++) begin
            @(posedge clock);
            @(negedge clock);
        end
        chk("mid_busy", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_bcd", 32'(bcd), 32'h0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_seg", 32'(seg), 32'h7F);
        chk("arst_an", 32'(an), 32'hF);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/score_display.md
# score_display

Display back-end for the brick game. It converts the 10-bit running score from the brick/score stage into four BCD digits using a sequential shift-and-add-3 engine. It then drives a time-multiplexed 4-digit, common-anode seven-segment display with leading-zero blanking. It runs on the fast system clock and treats the score, which comes from the slow game-tick domain, as a quasi-static bus.

## Interface
- SCAN_DIV, 50000: clock cycles each digit stays enabled. Minimum 2.
- clock  in  1  system clock (fast).
- reset  in  1  reset, asynchronous, active-low.
- score  in  10  binary score (0–1023) from the score stage; asynchronous to any scan timing.
- blank_zeros  in  1  1 = blank leading zero digits; units digit is never blanked.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- an  out  4  digit enables, active-low; an[0] = units … an[3] = thousands.
- bcd  out  16  last converted value {thousands, hundreds, tens, units}.
- busy  out  1  high while a conversion is in progress.

## Operation
- Input capture
  - s1 <= score; s2 <= s1 every cycle.
  - The score is "stable" when s1 == s2.
- Conversion FSM: IDLE, LOAD, SHIFT, DONE.
- IDLE
  - Go to LOAD when stable and s2 != last.
  - Otherwise stay in IDLE.
- LOAD
  - shift register <= {16'b0, s2}; last <= s2; iteration counter <= 0.
  - Go to SHIFT.
- SHIFT
  - Each cycle, add 3 to every BCD nibble ≥ 5, then shift the 26-bit register left by 1.
  - After 10 iterations, go to DONE.
- DONE
  - bcd <= upper 16 bits of the shift register.
  - Go to IDLE.
- busy = 1 in LOAD, SHIFT and DONE (registered from the state).
- Score change during conversion: ignored by the in-flight conversion. On return to IDLE, the new value differs from last, so a fresh conversion starts. No value is ever lost; the final bcd always matches the final settled score.
- Thousands nibble is only ever 0 or 1. Values 1000–1023 must convert correctly (no saturation).
- Scan
  - Counter runs 0..SCAN_DIV-1.
  - On wrap, the digit index advances 0→1→2→3→0.
- Blanking when blank_zeros = 1:
  - thousands digit blank if bcd[15:12] == 0;
  - hundreds digit blank if bcd[15:8] == 0;
  - tens digit blank if bcd[15:4] == 0.
- Output drive
  - Active digit: an = ~(4'b1 << idx), seg = encoding of the selected nibble.
  - Blanked digit: an = 4'hF, seg = 7'h7F.
  - seg and an are registered.
- Segment encoding (active-low, gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any other nibble value → 1111111.

## Timing
- Reset values: seg = 7'h7F, an = 4'hF, bcd = 0, busy = 0, state = IDLE, last = 0, idx = 0, scan counter = 0, s1 = s2 = 0.
  - A score of 0 after reset therefore triggers no conversion.
- Conversion latency: let the new score be captured into s1 at edge E0.
  - E1: s2 captures the new score.
  - E2: IDLE→LOAD.
  - E3: load.
  - E4–E13: ten shifts.
  - E14: bcd updated.
  - busy is high after E2 through E14 and low after E15.
- Display latency: seg/an reflect idx and bcd one cycle after they change.
  - First digit enable (an = 4'b1110, seg = "0") appears after the first edge following reset release.
- Each digit is enabled for exactly SCAN_DIV cycles; full refresh period is 4·SCAN_DIV.
- Reset asserted mid-conversion: all state returns to reset values immediately. The conversion is discarded; bcd = 0.

## Test plan
- Reset behaviour, SCAN_DIV = 4, score = 0, blank_zeros = 1:
  - During reset: seg = 7F, an = F, bcd = 0, busy = 0.
  - After release: units shows 1000000 with an = 1110; the other digits are blank; each slot lasts 4 cycles.
- Basic conversion, score 0→123 held:
  - bcd = 16'h0123 exactly 14 edges after s1 capture; busy high for 13 cycles.
  - Thousands digit blanked; hundreds shows 1111001.
- Boundary values:
  - score = 1023 → bcd = 16'h1023.
  - score = 999 → bcd = 16'h0999.
  - score = 1000 → bcd = 16'h1000; with blank_zeros = 1, all four digits are lit.
- Change mid-conversion:
  - Set score = 45, then change to 47 at edge E6.
  - bcd passes through 16'h0045, then settles at 16'h0047; busy re-asserts once.
- One-cycle glitch: score toggles to 512 for a single cycle, then returns to 7.
  - No conversion starts (s1 != s2).
  - bcd stays at 16'h0007.
- Blanking off and async reset:
  - blank_zeros = 0, score = 5 → all four digits lit ("0005").
  - Assert reset mid-SHIFT → bcd = 0, busy = 0 immediately.
